// File: rtl/code_lock_param.sv
// rtl/code_lock_param.sv - serial-code lock with timed unlock and alarm lockout
// Optional code reprogramming from OPEN is enabled by defining CODE_PROG_EN.
module code_lock_param #(
  parameter int                  CODE_LEN    = 5,
  parameter logic [CODE_LEN-1:0] CODE        = 5'b11011,
  parameter int                  MAX_TRIES   = 3,
  parameter int                  OPEN_CYC    = 8,
  parameter int                  LOCKOUT_CYC = 16,
  parameter int                  INACT_CYC   = 32
) (
  input  logic                          clk_100Mhz,
  input  logic                          reset,
  input  logic                          zero,
  input  logic                          one,
  input  logic                          prog,
  output logic                          unlock,
  output logic                          alarm,
  output logic [$clog2(CODE_LEN+1)-1:0] progress,
  output logic [3:0]                    fail_cnt,
  output logic [2:0]                    state_o
);

`ifdef CODE_PROG_EN
  localparam bit PROG_EN = 1'b1;
`else
  localparam bit PROG_EN = 1'b0;
`endif

  localparam int PW   = $clog2(CODE_LEN + 1);
  localparam int TMAX = (OPEN_CYC > LOCKOUT_CYC) ? OPEN_CYC : LOCKOUT_CYC;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int IW   = $clog2(INACT_CYC + 1);

  typedef enum logic [2:0] {
    ST_ENTER   = 3'd0,
    ST_OPEN    = 3'd1,
    ST_LOCKOUT = 3'd2,
    ST_PROG    = 3'd3
  } state_t;

  state_t              state, state_n;
  logic [CODE_LEN-1:0] shift_reg, shift_n;
  logic [CODE_LEN-1:0] code_reg, code_n;
  logic [PW-1:0]       progress_n;
  logic [3:0]          fail_n;
  logic [TW-1:0]       timer, timer_n;
  logic [IW-1:0]       inact, inact_n;
  logic                unlock_n, alarm_n;

  logic                key;
  logic [CODE_LEN-1:0] word;
  logic [3:0]          fail_inc;
  logic                last_bit;

  assign key      = zero ^ one;
  assign word     = {shift_reg[CODE_LEN-2:0], one};
  assign fail_inc = (fail_cnt == 4'hF) ? fail_cnt : fail_cnt + 4'd1;
  assign last_bit = (progress == PW'(CODE_LEN - 1));
  assign state_o  = state;

  always_ff @(posedge clk_100Mhz or negedge reset) begin
    if (!reset) begin
      state     <= ST_ENTER;
      shift_reg <= '0;
      code_reg  <= CODE;
      progress  <= '0;
      fail_cnt  <= '0;
      timer     <= '0;
      inact     <= '0;
      unlock    <= 1'b0;
      alarm     <= 1'b0;
    end else begin
      state     <= state_n;
      shift_reg <= shift_n;
      code_reg  <= code_n;
      progress  <= progress_n;
      fail_cnt  <= fail_n;
      timer     <= timer_n;
      inact     <= inact_n;
      unlock    <= unlock_n;
      alarm     <= alarm_n;
    end
  end

  always_comb begin
    state_n    = state;
    shift_n    = shift_reg;
    code_n     = code_reg;
    progress_n = progress;
    fail_n     = fail_cnt;
    timer_n    = timer;
    inact_n    = inact;
    unlock_n   = unlock;
    alarm_n    = alarm;
    case (state)
      ST_ENTER: begin
        if (key) begin
          shift_n = word;
          inact_n = '0;
          if (last_bit) begin
            progress_n = '0;
            timer_n    = '0;
            if (word == code_reg) begin
              state_n  = ST_OPEN;
              unlock_n = 1'b1;
              fail_n   = '0;
            end else begin
              fail_n = fail_inc;
              if (fail_inc >= 4'(MAX_TRIES)) begin
                state_n = ST_LOCKOUT;
                alarm_n = 1'b1;
              end
            end
          end else begin
            progress_n = progress + 1'b1;
          end
        end else if (progress != '0) begin
          // Partial word abandoned: drop it silently, no failure counted.
          if (inact == IW'(INACT_CYC - 1)) begin
            progress_n = '0;
            inact_n    = '0;
          end else begin
            inact_n = inact + 1'b1;
          end
        end else begin
          inact_n = '0;
        end
      end
      ST_OPEN: begin
        if (PROG_EN && prog) begin
          state_n    = ST_PROG;
          unlock_n   = 1'b0;
          progress_n = '0;
          inact_n    = '0;
          timer_n    = '0;
        end else if (timer == TW'(OPEN_CYC - 1)) begin
          state_n  = ST_ENTER;
          unlock_n = 1'b0;
          timer_n  = '0;
        end else begin
          timer_n = timer + 1'b1;
        end
      end
      ST_LOCKOUT: begin
        if (timer == TW'(LOCKOUT_CYC - 1)) begin
          state_n = ST_ENTER;
          alarm_n = 1'b0;
          fail_n  = '0;
          timer_n = '0;
        end else begin
          timer_n = timer + 1'b1;
        end
      end
      ST_PROG: begin
        if (key) begin
          shift_n = word;
          inact_n = '0;
          if (last_bit) begin
            code_n     = word;
            progress_n = '0;
            state_n    = ST_ENTER;
          end else begin
            progress_n = progress + 1'b1;
          end
        end else if (inact == IW'(INACT_CYC - 1)) begin
          state_n    = ST_ENTER;
          progress_n = '0;
          inact_n    = '0;
        end else begin
          inact_n = inact + 1'b1;
        end
      end
      default: state_n = ST_ENTER;
    endcase
  end

endmodule

// File: tb/tb_code_lock_param.sv
// tb/tb_code_lock_param.sv - randomized bench for code_lock_param against a queue-based reference model
module tb_code_lock_param;
  localparam int             CODE_LEN    = 5;
  localparam logic [4:0]     CODE_BITS   = 5'b11011;
  localparam int             MAX_TRIES   = 3;
  localparam int             OPEN_CYC    = 8;
  localparam int             LOCKOUT_CYC = 16;
  localparam int             INACT_CYC   = 32;
  localparam int             M_ENTER = 0, M_OPEN = 1, M_LOCK = 2, M_PROG = 3;
`ifdef CODE_PROG_EN
  localparam bit PROG_EN = 1'b1;
`else
  localparam bit PROG_EN = 1'b0;
`endif

  logic       clk_100Mhz = 1'b0;
  logic       reset = 1'b0;
  logic       zero = 1'b0, one = 1'b0, prog = 1'b0;
  logic       unlock, alarm;
  logic [2:0] progress;
  logic [3:0] fail_cnt;
  logic [2:0] state_o;

  int n_checks = 0;
  int n_fail   = 0;

  int m_mode, m_fails, m_idle, m_rem, m_code;
  int m_bits[$];

  always #5 clk_100Mhz = ~clk_100Mhz;

  code_lock_param #(
    .CODE_LEN(CODE_LEN), .CODE(CODE_BITS), .MAX_TRIES(MAX_TRIES),
    .OPEN_CYC(OPEN_CYC), .LOCKOUT_CYC(LOCKOUT_CYC), .INACT_CYC(INACT_CYC)
  ) dut (
    .clk_100Mhz(clk_100Mhz), .reset(reset), .zero(zero), .one(one), .prog(prog),
    .unlock(unlock), .alarm(alarm), .progress(progress), .fail_cnt(fail_cnt), .state_o(state_o)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int word_value();
    int w = 0;
    foreach (m_bits[i]) w = w * 2 + m_bits[i];
    return w;
  endfunction

  task automatic model_reset();
    m_mode = M_ENTER; m_fails = 0; m_idle = 0; m_rem = 0; m_code = int'(CODE_BITS);
    m_bits.delete();
  endtask

  // One clock edge of the lock's behaviour, phrased in terms of words and countdowns.
  task automatic model_step(input logic z, input logic o, input logic p);
    bit k = z ^ o;
    if (!reset) begin
      model_reset();
      return;
    end
    case (m_mode)
      M_ENTER: begin
        if (k) begin
          m_bits.push_back(int'(o));
          m_idle = 0;
          if (m_bits.size() == CODE_LEN) begin
            int w = word_value();
            m_bits.delete();
            if (w == m_code) begin
              m_mode = M_OPEN; m_rem = OPEN_CYC; m_fails = 0;
            end else begin
              m_fails = (m_fails < 15) ? m_fails + 1 : 15;
              if (m_fails >= MAX_TRIES) begin
                m_mode = M_LOCK; m_rem = LOCKOUT_CYC;
              end
            end
          end
        end else if (m_bits.size() > 0) begin
          m_idle++;
          if (m_idle == INACT_CYC) begin
            m_bits.delete(); m_idle = 0;
          end
        end
      end
      M_OPEN: begin
        if (PROG_EN && p) begin
          m_mode = M_PROG; m_bits.delete(); m_idle = 0;
        end else begin
          m_rem--;
          if (m_rem == 0) m_mode = M_ENTER;
        end
      end
      M_LOCK: begin
        m_rem--;
        if (m_rem == 0) begin
          m_mode = M_ENTER; m_fails = 0;
        end
      end
      default: begin
        if (k) begin
          m_bits.push_back(int'(o));
          m_idle = 0;
          if (m_bits.size() == CODE_LEN) begin
            m_code = word_value(); m_bits.delete(); m_mode = M_ENTER;
          end
        end else begin
          m_idle++;
          if (m_idle == INACT_CYC) begin
            m_bits.delete(); m_idle = 0; m_mode = M_ENTER;
          end
        end
      end
    endcase
  endtask

  task automatic compare_all();
    check("unlock",   int'(unlock),   int'(m_mode == M_OPEN));
    check("alarm",    int'(alarm),    int'(m_mode == M_LOCK));
    check("progress", int'(progress), m_bits.size());
    check("fail_cnt", int'(fail_cnt), m_fails);
    check("state_o",  int'(state_o),  m_mode);
  endtask

  task automatic step(input logic z, input logic o, input logic p);
    zero = z; one = o; prog = p;
    @(posedge clk_100Mhz);
    model_step(z, o, p);
    #1;
    compare_all();
    zero = 1'b0; one = 1'b0; prog = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic send_word(input int value);
    for (int i = CODE_LEN - 1; i >= 0; i--) begin
      logic b = logic'((value >> i) & 1);
      step(~b, b, 1'b0);
    end
  endtask

  initial begin
    model_reset();
    #1;
    compare_all();
    idle(2);
    reset = 1'b1;
    idle(2);

    // 1: correct code opens for OPEN_CYC cycles
    send_word(5'b11011);
    check("t1_unlock", int'(unlock), 1);
    check("t1_state", int'(state_o), 1);
    idle(OPEN_CYC + 2);
    check("t1_closed", int'(unlock), 0);

    // 2: three wrong words trigger lockout; keys ignored during alarm
    send_word(5'b11111);
    send_word(5'b11111);
    send_word(5'b11111);
    check("t2_alarm", int'(alarm), 1);
    check("t2_fails", int'(fail_cnt), 3);
    send_word(5'b11011);
    idle(LOCKOUT_CYC);
    check("t2_fails_clr", int'(fail_cnt), 0);
    check("t2_state", int'(state_o), 0);

    // 3: partial word discarded after inactivity
    step(1'b0, 1'b1, 1'b0); step(1'b0, 1'b1, 1'b0); step(1'b1, 1'b0, 1'b0);
    idle(40);
    check("t3_progress", int'(progress), 0);
    check("t3_fails", int'(fail_cnt), 0);
    send_word(5'b11011);
    check("t3_unlock", int'(unlock), 1);
    idle(OPEN_CYC);

    // 4: both keys at once is no key; reset in OPEN clears immediately
    step(1'b0, 1'b1, 1'b0); step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    check("t4_both", int'(progress), 2);
    step(1'b0, 1'b1, 1'b0); step(1'b1, 1'b0, 1'b0); step(1'b0, 1'b1, 1'b0);
    idle(CODE_LEN);
    send_word(5'b11011);
    idle(3);
    #3 reset = 1'b0;
    #1;
    model_reset();
    compare_all();
    idle(2);
    reset = 1'b1;
    idle(1);

`ifdef CODE_PROG_EN
    // 5: reprogram from OPEN
    send_word(5'b11011);
    step(1'b0, 1'b0, 1'b1);
    check("t5_prog", int'(state_o), 3);
    send_word(5'b10101);
    check("t5_back", int'(state_o), 0);
    send_word(5'b11011);
    check("t5_old_fails", int'(fail_cnt), 1);
    send_word(5'b10101);
    check("t5_new_opens", int'(unlock), 1);
    idle(OPEN_CYC);
    #3 reset = 1'b0;
    #1 model_reset();
    idle(1);
    reset = 1'b1;
    idle(1);
`endif

    // Random phase: keys biased toward the current code, occasional idle gaps and resets
    for (int it = 0; it < 2500; it++) begin
      int r = $urandom_range(0, 99);
      logic p = ($urandom_range(0, 15) == 0);
      if (r < 2) begin
        idle(INACT_CYC + $urandom_range(0, 4) - 2);
      end else if (r < 3) begin
        #3 reset = 1'b0;
        #1 model_reset();
        compare_all();
        step(1'b0, 1'b1, 1'b0);
        reset = 1'b1;
      end else if (r < 15) begin
        step(1'b0, 1'b0, p);
      end else if (r < 20) begin
        step(1'b1, 1'b1, p);
      end else begin
        logic b;
        if (m_bits.size() < CODE_LEN && $urandom_range(0, 9) < 7)
          b = logic'((m_code >> (CODE_LEN - 1 - m_bits.size())) & 1);
        else
          b = logic'($urandom_range(0, 1));
        step(~b, b, p);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
